seq_det_sched: RTL and testbench
================================

// Module: seq_det_sched
// PURPOSE
//  Streaming controller for a programmable serial sequence detector (generalises the fixed 110 detectors).
//  - Accepts parallel words over a valid/ready handshake and serialises them MSB-first, one bit per clock.
//  - Matches the bit stream against a runtime-configurable pattern of 1..8 bits, overlapping or non-overlapping.
//  - Counts matches and flags end of each word. Sits between a word source and match-consuming logic.
// PARAMETERS
//  W          8        word width, 2..32
//  CW         8        match_count width
//  PAT_RST    8'h06    pattern after reset (LSB = last bit received), i.e. 110
//  LEN_RST    3        pattern length after reset
// PORTS
//  clk          in   1    clock, rising edge
//  reset        in   1    asynchronous, active-high
//  clr          in   1    sync clear: history, match_count, FSM to IDLE
//  cfg_we       in   1    config write strobe
//  cfg_pattern  in   8    pattern, bit[len-1] compared first, bit0 last
//  cfg_len      in   4    pattern length, legal 1..8
//  cfg_overlap  in   1    1 = overlapping detection
//  word_valid   in   1    word_data valid
//  word_data    in   W    word to serialise
//  word_ready   out  1    controller can accept a word
//  bit_out      out  1    current serial bit
//  bit_valid    out  1    bit_out valid this cycle
//  match        out  1    registered match pulse
//  match_count  out  CW   saturating match counter
//  done         out  1    one-cycle pulse after a word's last bit
//  cfg_err      out  1    one-cycle pulse, config write rejected
// BEHAVIOUR
//  - Reset values:
//    - FSM=IDLE; word_ready=1; bit_valid=0; bit_out=0; match=0; match_count=0; done=0; cfg_err=0.
//    - pattern=PAT_RST, len=LEN_RST, overlap=1, history=0, hist_cnt=0.
//  - FSM IDLE/SHIFT/DONE:
//    - IDLE: word_ready=1. Handshake is valid&&ready at a clock edge; it latches word_data into the shift register, bit index=W-1, goes to SHIFT.
//    - SHIFT: bit_valid=1, bit_out=sreg MSB; sreg shifts left each cycle; after exactly W SHIFT cycles goes to DONE.
//    - DONE: done=1 for one cycle, word_ready=0, then IDLE.
//    - Throughput is one word per W+2 cycles; word_ready=0 in SHIFT and DONE.
//  - Detector, on each edge with bit_valid=1:
//    - hist <= {hist[6:0],bit_out}; hist_cnt <= min(hist_cnt+1,8).
//    - match <= (hist_cnt_next >= len) && (hist_next[len-1:0] == pattern[len-1:0]); otherwise match <= 0.
//    - match therefore appears the cycle after the matching bit; the last bit's match coincides with done.
//    - On a match: match_count += 1, saturating at 2^CW-1. If overlap=0, hist_cnt <= 0, so the next match needs len fresh bits.
//    - History persists across words: a pattern may straddle a word boundary.
//  - Config:
//    - cfg_we in IDLE with cfg_len in 1..8 updates pattern/len/overlap at the edge and clears hist and hist_cnt.
//    - cfg_we in SHIFT/DONE, or cfg_len 0 or >8: no change, cfg_err=1 next cycle.
//    - cfg_we and a word handshake in the same IDLE cycle: config applies first; the word uses the new config.
//  - clr:
//    - Overrides everything: FSM to IDLE, the in-flight word is dropped.
//    - Clears hist, hist_cnt and match_count; match=0, done=0.
//    - word_ready=0 while clr=1, so no word is accepted; cfg_we is ignored (no cfg_err).
//  - Reset asserted mid-word: all state returns to reset values immediately; the partial word is lost.
// TESTING
//  1. Defaults, W=8, word 8'b11011011 -> bit_valid 8 cycles, bits 1,1,0,1,1,0,1,1; match after bits 3 and 6; count=2; done one cycle.
//  2. cfg 101/len3/overlap=1, word 8'b10101010 -> matches after bits 3,5,7; count=3. With overlap=0 -> bits 3,7; count=2.
//  3. Straddle: defaults, word 8'h03 then 8'h00 -> single match on first bit of word 2; count=1.
//  4. cfg_len=0 in IDLE, and cfg_we during SHIFT -> cfg_err pulse each time; pattern still 110 (re-run test 1, count=2).
//  5. clr at 4th SHIFT cycle -> next cycle IDLE, word_ready=1, count=0, no done; reset mid-SHIFT -> all outputs at reset values.
//  6. CW=2, stream 4 matching words of test 1 -> match_count saturates at 3, match still pulses.

Source files
------------

// File: rtl/seq_det_sched.sv
`default_nettype none
// ============================================================================
//  Module   : seq_det_sched
//  Purpose  : Accepts parallel words over valid/ready, shifts them out
//             MSB-first one bit per clock, and matches the serial stream
//             against a runtime-programmable 1..8 bit pattern (overlapping
//             or non-overlapping). Counts matches and flags end of word.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_det_sched #(
   parameter int         W       = 8,
   parameter int         CW      = 8,
   parameter logic [7:0] PAT_RST = 8'h06,
   parameter logic [3:0] LEN_RST = 4'd3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          cfg_we,
   input  logic [7:0]    cfg_pattern,
   input  logic [3:0]    cfg_len,
   input  logic          cfg_overlap,
   input  logic          word_valid,
   input  logic [W-1:0]  word_data,
   output logic          word_ready,
   output logic          bit_out,
   output logic          bit_valid,
   output logic          match,
   output logic [CW-1:0] match_count,
   output logic          done,
   output logic          cfg_err
);

   localparam int IW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t        state;
   state_t        state_next;
   logic [W-1:0]  sreg;
   logic [IW-1:0] bit_idx;

   logic [7:0]    pattern;
   logic [3:0]    len;
   logic          overlap;
   logic [7:0]    hist;
   logic [3:0]    hist_cnt;

   logic          accept;
   logic          cfg_ok;
   logic          cfg_bad;
   logic [3:0]    cnt_inc;
   logic [7:0]    hist_nx;
   logic [8:0]    mask_wide;
   logic [7:0]    len_mask;
   logic          hit;

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic and handshake/strobe outputs; clr forces IDLE and blocks everything
   always_comb begin
      state_next = state;
      word_ready = 1'b0;
      bit_valid  = 1'b0;
      done       = 1'b0;
      if (clr) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               word_ready = 1'b1;
               if (word_valid) state_next = SHIFT;
            end
            SHIFT: begin
               bit_valid = 1'b1;
               if (bit_idx == '0) state_next = DONE;
            end
            DONE: begin
               done       = 1'b1;
               state_next = IDLE;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   assign accept  = word_ready & word_valid;
   assign bit_out = bit_valid & sreg[W-1];

   // A config write is only legal in IDLE with a length of 1..8; anything else is flagged
   assign cfg_ok  = cfg_we && !clr && (state == IDLE) && (cfg_len != 4'd0) && (cfg_len <= 4'd8);
   assign cfg_bad = cfg_we && !clr && !cfg_ok;

   // Detector evaluation for the bit being shifted out this cycle
   assign cnt_inc   = (hist_cnt >= 4'd8) ? 4'd8 : hist_cnt + 4'd1;
   assign hist_nx   = {hist[6:0], bit_out};
   assign mask_wide = (9'd1 << len) - 9'd1;
   assign len_mask  = mask_wide[7:0];
   assign hit       = (cnt_inc >= len) && ((hist_nx & len_mask) == (pattern & len_mask));

   // Shift register and bit index: load on handshake, shift while in SHIFT
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sreg    <= '0;
         bit_idx <= '0;
      end else if (accept) begin
         sreg    <= word_data;
         bit_idx <= IW'(W - 1);
      end else if (state == SHIFT) begin
         sreg    <= {sreg[W-2:0], 1'b0};
         bit_idx <= bit_idx - 1'b1;
      end
   end

   // Config registers, match history, match pulse and saturating counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pattern     <= PAT_RST;
         len         <= LEN_RST;
         overlap     <= 1'b1;
         hist        <= '0;
         hist_cnt    <= '0;
         match       <= 1'b0;
         match_count <= '0;
         cfg_err     <= 1'b0;
      end else begin
         cfg_err <= cfg_bad;
         match   <= 1'b0;
         if (clr) begin
            hist        <= '0;
            hist_cnt    <= '0;
            match_count <= '0;
         end else if (cfg_ok) begin
            pattern  <= cfg_pattern;
            len      <= cfg_len;
            overlap  <= cfg_overlap;
            hist     <= '0;
            hist_cnt <= '0;
         end else if (bit_valid) begin
            hist  <= hist_nx;
            match <= hit;
            // Non-overlapping mode restarts the fill count so the next match needs len fresh bits
            hist_cnt <= (hit && !overlap) ? 4'd0 : cnt_inc;
            if (hit && (match_count != {CW{1'b1}}))
               match_count <= match_count + CW'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seq_det_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_det_sched
//  Purpose  : Directed, table-driven self-checking bench for seq_det_sched.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_det_sched;

   localparam int W = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic       clr;
   logic       cfg_we;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
   logic       cfg_overlap;
   logic       word_valid;
   logic [7:0] word_data;

   logic       word_ready, bit_out, bit_valid, match, done, cfg_err;
   logic [7:0] match_count;
   logic       word_ready2, bit_out2, bit_valid2, match2, done2, cfg_err2;
   logic [1:0] match_count2;

   int n_cmp = 0;
   int n_err = 0;

   // captured per-word results
   logic [7:0] r_bits, r_mv, r_mv2;
   int         r_nbits, r_ndone;

   always #5 clk = ~clk;

   seq_det_sched #(.W(W), .CW(8)) u_dut (
      .clk(clk), .reset(reset), .clr(clr), .cfg_we(cfg_we),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
      .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
      .bit_out(bit_out), .bit_valid(bit_valid), .match(match),
      .match_count(match_count), .done(done), .cfg_err(cfg_err)
   );

   seq_det_sched #(.W(W), .CW(2)) u_sat (
      .clk(clk), .reset(reset), .clr(clr), .cfg_we(cfg_we),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
      .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready2),
      .bit_out(bit_out2), .bit_valid(bit_valid2), .match(match2),
      .match_count(match_count2), .done(done2), .cfg_err(cfg_err2)
   );

   typedef struct {
      bit         do_cfg;
      logic [7:0] pat;
      logic [3:0] len;
      bit         ovl;
      bit         do_clr;
      logic [7:0] word;
      logic [7:0] exp_mv;   // bit (W-k) set = match after k-th transmitted bit
      int         exp_cnt;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called just after a negedge; returns just after the following negedge
   task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input logic o, input logic exp_err);
      cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
      @(posedge clk); #1 cfg_we = 1'b0;
      @(negedge clk);
      chk("cfg_err", {31'd0, cfg_err}, {31'd0, exp_err});
   endtask

   task automatic do_clr();
      clr = 1'b1;
      #1 chk("ready_in_clr", {31'd0, word_ready}, 32'd0);
      @(posedge clk); #1 clr = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_word(input logic [7:0] w);
      int n;
      word_valid = 1'b1; word_data = w;
      n = 0;
      while (!word_ready && n < 50) begin @(negedge clk); n++; end
      if (!word_ready) chk("ready_timeout", 32'd0, 32'd1);
      @(posedge clk); #1 word_valid = 1'b0;
      r_bits = '0; r_mv = '0; r_mv2 = '0; r_nbits = 0; r_ndone = 0;
      for (int c = 0; c <= W; c++) begin
         @(negedge clk);
         if (bit_valid) r_nbits++;
         if (c < W) r_bits[W-1-c] = bit_out;
         if (c >= 1 && match)  r_mv[W-c]  = 1'b1;
         if (c >= 1 && match2) r_mv2[W-c] = 1'b1;
         if (done) r_ndone++;
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{0, 8'h00, 4'd0, 0, 1, 8'hDB, 8'h24, 2};
      vecs[1] = '{1, 8'h05, 4'd3, 1, 1, 8'hAA, 8'h2A, 3};
      vecs[2] = '{1, 8'h05, 4'd3, 0, 1, 8'hAA, 8'h22, 2};
      vecs[3] = '{1, 8'h06, 4'd3, 1, 1, 8'h03, 8'h00, 0};
      vecs[4] = '{0, 8'h00, 4'd0, 0, 0, 8'h00, 8'h80, 1};
      vecs[5] = '{1, 8'h01, 4'd1, 1, 1, 8'h81, 8'h81, 2};
      vecs[6] = '{1, 8'hA5, 4'd8, 1, 1, 8'hA5, 8'h01, 1};
      vecs[7] = '{0, 8'h00, 4'd0, 0, 0, 8'hA5, 8'h01, 2};
      vecs[8] = '{1, 8'h03, 4'd2, 0, 1, 8'hFF, 8'h55, 4};
      vecs[9] = '{1, 8'h03, 4'd2, 1, 1, 8'hFF, 8'h7F, 7};

      reset = 1'b1; clr = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0;
      cfg_overlap = 1'b0; word_valid = 1'b0; word_data = '0;
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // reset values
      chk("rst_word_ready", {31'd0, word_ready}, 32'd1);
      chk("rst_bit_valid",  {31'd0, bit_valid},  32'd0);
      chk("rst_bit_out",    {31'd0, bit_out},    32'd0);
      chk("rst_match",      {31'd0, match},      32'd0);
      chk("rst_count",      {24'd0, match_count}, 32'd0);
      chk("rst_done",       {31'd0, done},       32'd0);
      chk("rst_cfg_err",    {31'd0, cfg_err},    32'd0);

      // table-driven words
      for (int i = 0; i < 10; i++) begin
         if (vecs[i].do_cfg) do_cfg(vecs[i].pat, vecs[i].len, vecs[i].ovl, 1'b0);
         if (vecs[i].do_clr) do_clr();
         send_word(vecs[i].word);
         chk($sformatf("v%0d_bits", i),  {24'd0, r_bits}, {24'd0, vecs[i].word});
         chk($sformatf("v%0d_nbits", i), r_nbits, W);
         chk($sformatf("v%0d_done", i),  r_ndone, 1);
         chk($sformatf("v%0d_match", i), {24'd0, r_mv}, {24'd0, vecs[i].exp_mv});
         chk($sformatf("v%0d_match_sat", i), {24'd0, r_mv2}, {24'd0, vecs[i].exp_mv});
         chk($sformatf("v%0d_count", i), {24'd0, match_count}, vecs[i].exp_cnt);
         chk($sformatf("v%0d_count_sat", i), {30'd0, match_count2},
             (vecs[i].exp_cnt > 3) ? 32'd3 : vecs[i].exp_cnt);
      end

      // illegal config: length 0 in IDLE, then error pulse ends
      do_cfg(8'h05, 4'd0, 1'b1, 1'b1);
      @(negedge clk);
      chk("cfg_err_one_cycle", {31'd0, cfg_err}, 32'd0);
      do_cfg(8'h06, 4'd3, 1'b1, 1'b0);

      // config write during SHIFT is rejected
      word_valid = 1'b1; word_data = 8'hDB;
      @(posedge clk); #1 word_valid = 1'b0;
      @(negedge clk);
      cfg_we = 1'b1; cfg_pattern = 8'h05; cfg_len = 4'd3;
      @(posedge clk); #1 cfg_we = 1'b0;
      @(negedge clk);
      chk("cfg_err_shift", {31'd0, cfg_err}, 32'd1);
      for (int n = 0; n < 20 && !word_ready; n++) @(negedge clk);
      chk("idle_after_word", {31'd0, word_ready}, 32'd1);
      do_clr();
      send_word(8'hDB);
      chk("cfg_kept_match", {24'd0, r_mv}, 32'h24);
      chk("cfg_kept_count", {24'd0, match_count}, 32'd2);

      // clr at the 4th SHIFT cycle
      word_valid = 1'b1; word_data = 8'hDB;
      @(posedge clk); #1 word_valid = 1'b0;
      for (int c = 0; c < 4; c++) @(negedge clk);
      chk("pre_clr_match", {31'd0, match}, 32'd1);
      clr = 1'b1;
      @(posedge clk); #1 clr = 1'b0;
      @(negedge clk);
      chk("clr_word_ready", {31'd0, word_ready}, 32'd1);
      chk("clr_bit_valid",  {31'd0, bit_valid},  32'd0);
      chk("clr_count",      {24'd0, match_count}, 32'd0);
      chk("clr_match",      {31'd0, match},      32'd0);
      r_ndone = 0;
      for (int c = 0; c < 12; c++) begin
         if (done) r_ndone++;
         @(negedge clk);
      end
      chk("clr_no_done", r_ndone, 0);

      // reset mid-SHIFT restores everything, including the default pattern
      do_cfg(8'h05, 4'd3, 1'b1, 1'b0);
      word_valid = 1'b1; word_data = 8'hAA;
      @(posedge clk); #1 word_valid = 1'b0;
      for (int c = 0; c < 3; c++) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("arst_word_ready", {31'd0, word_ready}, 32'd1);
      chk("arst_bit_valid",  {31'd0, bit_valid},  32'd0);
      chk("arst_bit_out",    {31'd0, bit_out},    32'd0);
      chk("arst_match",      {31'd0, match},      32'd0);
      chk("arst_count",      {24'd0, match_count}, 32'd0);
      chk("arst_done",       {31'd0, done},       32'd0);
      @(negedge clk); reset = 1'b0;
      @(negedge clk);
      send_word(8'hDB);
      chk("arst_pattern_match", {24'd0, r_mv}, 32'h24);
      chk("arst_pattern_count", {24'd0, match_count}, 32'd2);

      // saturation with a 2-bit counter over four matching words
      do_clr();
      for (int k = 0; k < 4; k++) send_word(8'hDB);
      chk("sat_count",      {30'd0, match_count2}, 32'd3);
      chk("sat_match",      {24'd0, r_mv2}, 32'h24);
      chk("unsat_count",    {24'd0, match_count}, 32'd8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
